// File: rtl/spi_controller.sv
// ============================================================================
// Module   : spi_controller
// Purpose  : SPI mode-0 bus initiator issuing 16-bit register access frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    input  logic       cipo
);

    localparam int c_max_a   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int c_max_b   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int c_cnt_max = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_div_last   = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(CS_SETUP - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(CS_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_idle_last  = c_cnt_w'(CS_IDLE - 1);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_setup    = 3'd1;
    localparam logic [2:0] c_st_shift_lo = 3'd2;
    localparam logic [2:0] c_st_shift_hi = 3'd3;
    localparam logic [2:0] c_st_hold     = 3'd4;
    localparam logic [2:0] c_st_gap      = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_phase_last;
    logic               w_phase_done;
    logic [3:0]         r_bit_cnt;
    logic [15:0]        r_tx;
    logic [7:0]         r_rx;
    logic [7:0]         r_rdata;
    logic               w_accept;

    assign w_accept = (r_state == c_st_idle) && req_valid;

    always_comb begin
        w_phase_last = c_div_last;
        case (r_state)
            c_st_setup: w_phase_last = c_setup_last;
            c_st_hold:  w_phase_last = c_hold_last;
            c_st_gap:   w_phase_last = c_idle_last;
            default:    w_phase_last = c_div_last;
        endcase
        w_phase_done = (r_cnt == w_phase_last);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:     if (req_valid)    w_next_state = c_st_setup;
            c_st_setup:    if (w_phase_done) w_next_state = c_st_shift_lo;
            c_st_shift_lo: if (w_phase_done) w_next_state = c_st_shift_hi;
            c_st_shift_hi: if (w_phase_done)
                               w_next_state = (r_bit_cnt == 4'd15) ? c_st_hold : c_st_shift_lo;
            c_st_hold:     if (w_phase_done) w_next_state = c_st_gap;
            c_st_gap:      if (w_phase_done) w_next_state = c_st_idle;
            default:       w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_bit_cnt <= 4'd0;
            r_tx      <= 16'h0000;
            r_rx      <= 8'h00;
            r_rdata   <= 8'h00;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || (r_state == c_st_idle))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (w_accept) begin
                r_tx      <= {req_write, req_addr, (req_write ? req_wdata : 8'h00)};
                r_bit_cnt <= 4'd0;
                r_rx      <= 8'h00;
            end

            // Sample cipo at the end of the high phase; the next bit goes out as sclk falls.
            if ((r_state == c_st_shift_hi) && w_phase_done) begin
                r_rx <= {r_rx[6:0], cipo};
                r_tx <= {r_tx[14:0], 1'b0};
                if (r_bit_cnt != 4'd15)
                    r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if ((r_state == c_st_hold) && w_phase_done)
                r_rdata <= r_rx;
        end
    end

    always_comb begin
        req_ready = (r_state == c_st_idle);
        busy      = (r_state != c_st_idle);
        ncs       = !((r_state == c_st_setup) || (r_state == c_st_shift_lo) ||
                      (r_state == c_st_shift_hi) || (r_state == c_st_hold));
        sclk      = (r_state == c_st_shift_hi);
        copi      = ((r_state == c_st_setup) || (r_state == c_st_shift_lo) ||
                     (r_state == c_st_shift_hi)) ? r_tx[15] : 1'b0;
        rsp_valid = (r_state == c_st_gap) && (r_cnt == '0);
        rsp_rdata = r_rdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// ============================================================================
// Module   : tb_spi_controller
// Purpose  : Scoreboard bench for spi_controller with a mode-0 peripheral model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_controller;

    localparam int c_low_default = 2 + 32 * 4 + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy, sclk, copi, ncs;
    logic       cipo;

    logic       req_valid2, req_ready2, rsp_valid2, busy2, sclk2, copi2, ncs2;
    logic [7:0] rsp_rdata2;
    logic       cipo2 = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
    } exp_t;
    exp_t sb[$];

    logic [7:0]  periph_byte = 8'h00;
    logic [15:0] periph_sh;

    int          m_low, m_rises, m_high;
    logic [15:0] m_frame;
    logic        m_prev_ncs, m_prev_sclk;

    always #5 clk = ~clk;

    spi_controller u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo)
    );

    spi_controller #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(1'b1), .req_addr(7'h12), .req_wdata(8'h3C),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .sclk(sclk2), .copi(copi2), .ncs(ncs2), .cipo(cipo2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Peripheral: loads its reply when selected, shifts on every sclk fall.
    always @(negedge ncs) begin
        periph_sh = {8'h00, periph_byte};
        cipo      = periph_sh[15];
    end
    always @(negedge sclk) begin
        periph_sh = {periph_sh[14:0], 1'b0};
        cipo      = periph_sh[15];
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_low = 0; m_rises = 0; m_high = 100; m_frame = 16'h0;
            m_prev_ncs = 1'b1; m_prev_sclk = 1'b0;
        end else begin
            check("sclk_while_ncs_high", sclk & ncs, 1'b0);
            if (!ncs) begin
                if (m_prev_ncs) begin
                    check("cs_idle_gap", m_high >= 2, 1'b1);
                    m_low = 0; m_rises = 0; m_frame = 16'h0;
                end
                m_low++;
                check("ready_in_frame", req_ready, 1'b0);
                check("busy_in_frame", busy, 1'b1);
                if (sclk && !m_prev_sclk) begin
                    m_rises++;
                    m_frame = {m_frame[14:0], copi};
                end
            end else begin
                if (!m_prev_ncs) m_high = 1;
                else             m_high++;
            end
            if (rsp_valid) begin
                check("rsp_at_ncs_rise", ncs && !m_prev_ncs, 1'b1);
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("frame_bits", m_frame, e.frame);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("ncs_low_cycles", m_low, c_low_default);
                    check("sclk_rises", m_rises, 16);
                end
            end else if (ncs && !m_prev_ncs) begin
                check("ncs_rise_without_rsp", 1'b0, 1'b1);
            end
            m_prev_ncs  = ncs;
            m_prev_sclk = sclk;
        end
    end

    task automatic accept_current();
        int n;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", req_ready, 1'b1);
        @(posedge clk);
        sb.push_back('{frame: {req_write, req_addr, (req_write ? req_wdata : 8'h00)},
                       rdata: periph_byte});
        #1;
    endtask

    task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        accept_current();
        req_valid = 1'b0;
        req_write = ~w; req_addr = ~a; req_wdata = ~d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(req_ready && sb.size() == 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", req_ready && sb.size() == 0, 1'b1);
    endtask

    initial begin
        int rises, low, first, second, pulses;
        logic prev;
        logic [15:0] f2;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 7'h0;
        req_wdata = 8'h0; req_valid2 = 1'b0; cipo = 1'b0;
        #12;
        check("rst_ncs", ncs, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_copi", copi, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 8'h00);
        @(negedge clk); #2 rst_n = 1'b1;

        periph_byte = 8'h5A;
        send(1'b1, 7'h00, 8'hA5);
        wait_idle();
        check("rdata_held", rsp_rdata, 8'h5A);

        periph_byte = 8'h3C;
        send(1'b0, 7'h03, 8'hFF);
        wait_idle();

        periph_byte = 8'hC3;
        @(negedge clk);
        req_write = 1'b1; req_addr = 7'h11; req_wdata = 8'h22; req_valid = 1'b1;
        accept_current();
        req_addr = 7'h44; req_wdata = 8'h99; req_write = 1'b0;
        @(negedge clk);
        accept_current();
        req_valid = 1'b0;
        wait_idle();

        periph_byte = 8'h81;
        send(1'b1, 7'h0A, 8'h0F);
        repeat (30) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h55; req_wdata = 8'hEE;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();

        send(1'b1, 7'h2A, 8'h0F);
        rises = 0; prev = 1'b0;
        for (int c = 0; c < 200 && rises < 5; c++) begin
            @(negedge clk);
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        check("rises_before_reset", rises, 5);
        #3 rst_n = 1'b0;
        #1;
        check("abort_ncs", ncs, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_ready", req_ready, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        sb.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        periph_byte = 8'h77;
        send(1'b0, 7'h7F, 8'h00);
        wait_idle();

        @(negedge clk);
        req_valid2 = 1'b1;
        @(posedge clk); #1 req_valid2 = 1'b0;
        low = 0; rises = 0; first = -1; second = -1; pulses = 0; prev = 1'b0; f2 = 16'h0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!ncs2) low++;
            if (sclk2 && !prev) begin
                rises++;
                f2 = {f2[14:0], copi2};
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            prev = sclk2;
            if (rsp_valid2) begin
                pulses++;
                check("div2_rdata", rsp_rdata2, 8'hFF);
            end
        end
        check("div2_ncs_low", low, 68);
        check("div2_rises", rises, 16);
        check("div2_period", second - first, 4);
        check("div2_pulses", pulses, 1);
        check("div2_frame", f2, 16'h923C);
        check("div2_busy_end", busy2, 1'b0);
        check("div2_ready_end", req_ready2, 1'b1);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
